// File: rtl/argmax_pkg.sv
// argmax_pkg: shared definitions for the sequential arg-max engine.
//   ARGMAX_DATA_W  : score width
//   argmax_state_t : engine FSM states
package argmax_pkg;
    localparam int ARGMAX_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } argmax_state_t;
endpackage

// File: rtl/argmax_less32.sv
// argmax_less32: combinational 32-bit less-than with signed/unsigned select.
// Ports:
//   a, b  : operands
//   umode : 1 = unsigned compare, 0 = two's-complement signed compare
//   less  : a < b under the selected interpretation
module argmax_less32
    import argmax_pkg::*;
(
    input  logic [ARGMAX_DATA_W-1:0] a,
    input  logic [ARGMAX_DATA_W-1:0] b,
    input  logic                     umode,
    output logic                     less
);
    logic [ARGMAX_DATA_W-1:0] a_k;
    logic [ARGMAX_DATA_W-1:0] b_k;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    always_comb begin
        a_k = a;
        b_k = b;
        if (!umode) begin
            a_k[ARGMAX_DATA_W-1] = ~a[ARGMAX_DATA_W-1];
            b_k[ARGMAX_DATA_W-1] = ~b[ARGMAX_DATA_W-1];
        end
    end

    assign less = (a_k < b_k);
endmodule

// File: rtl/argmax_seq.sv
// argmax_seq: streams scores over valid/ready and returns the maximum and the
// index of its first occurrence, using a single shared less-than comparator.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start, len, umode    : job request (sampled in IDLE), length, compare mode
//   in_valid/in_ready/in_data : score stream
//   out_valid/out_ready  : result handshake
//   max_val, max_idx     : result (registered, stable while out_valid)
//   empty                : job had len = 0
//   busy                 : engine not idle
module argmax_seq
    import argmax_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     umode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ARGMAX_DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ARGMAX_DATA_W-1:0] max_val,
    output logic [LEN_W-1:0]         max_idx,
    output logic                     empty,
    output logic                     busy
);
    argmax_state_t            state, state_nxt;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         count;
    logic [LEN_W-1:0]         count_inc;
    logic [LEN_W-1:0]         idx;
    logic [ARGMAX_DATA_W-1:0] best;
    logic                     umode_q;
    logic                     empty_q;
    logic                     less;
    logic                     in_fire;
    logic                     out_fire;

    assign in_ready  = (state == FIRST) || (state == RUN);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // count < len_q <= 2^LEN_W-1 whenever this is used, so it cannot wrap.
    assign count_inc = count + LEN_W'(1);

    assign max_val = best;
    assign max_idx = idx;
    assign empty   = empty_q;

    argmax_less32 u_less (
        .a     (best),
        .b     (in_data),
        .umode (umode_q),
        .less  (less)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : FIRST;
            FIRST:   if (in_fire) state_nxt = (len_q == LEN_W'(1)) ? DONE : RUN;
            RUN:     if (in_fire && (count_inc == len_q)) state_nxt = DONE;
            DONE:    if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            umode_q <= 1'b0;
            best    <= '0;
            idx     <= '0;
            count   <= '0;
            empty_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_q   <= len;
                    umode_q <= umode;
                    // Cleared so a zero-length job reports 0/0.
                    best    <= '0;
                    idx     <= '0;
                    count   <= '0;
                    empty_q <= (len == '0);
                end
                FIRST: if (in_fire) begin
                    best  <= in_data;
                    idx   <= '0;
                    count <= LEN_W'(1);
                end
                RUN: if (in_fire) begin
                    // Strict less-than: ties keep the earlier index.
                    if (less) begin
                        best <= in_data;
                        idx  <= count;
                    end
                    count <= count_inc;
                end
                DONE: if (out_fire) empty_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_seq.sv
// tb_argmax_seq: randomized self-checking bench for argmax_seq against a
// queue-based arg-max reference model; also exercises argmax_less32 alone.
module tb_argmax_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        umode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] max_val;
    logic [7:0]  max_idx;
    logic        empty;
    logic        busy;

    logic [31:0] la = '0, lb = '0;
    logic        lu = 1'b0, ll;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    argmax_seq #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .umode(umode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .max_val(max_val), .max_idx(max_idx), .empty(empty), .busy(busy)
    );

    argmax_less32 u_less (.a(la), .b(lb), .umode(lu), .less(ll));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: first element seeds, later elements replace only if strictly greater.
    function automatic void model(input logic um, input int n,
                                  output logic [31:0] mv, output logic [31:0] mi);
        mv = '0;
        mi = '0;
        for (int k = 0; k < n; k++) begin
            logic gt;
            gt = um ? (q[k] > mv) : ($signed(q[k]) > $signed(mv));
            if (k == 0 || gt) begin
                mv = q[k];
                mi = 32'(k);
            end
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_iready"}, 32'(in_ready), 32'd0);
        chk({tag, "_val"}, max_val, 32'd0);
        chk({tag, "_idx"}, 32'(max_idx), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // mode: 0 back-to-back, 1 alternating 1-0-1..., 2 random bubbles.
    // abort_at >= 0 asserts reset after that many handshakes.
    task automatic run_job(input string tag, input logic um, input int n,
                           input int mode, input int hold, input int abort_at);
        logic [31:0] mv, mi;
        int i, cyc;
        logic v, hs;
        model(um, n, mv, mi);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        start = 1'b1; len = 8'(n); umode = um;
        @(negedge clk);
        start = 1'b0; len = 8'($urandom); umode = 1'($urandom);
        if (n == 0) begin
            chk({tag, "_no_ready"}, 32'(in_ready), 32'd0);
        end else begin
            chk({tag, "_ready_t1"}, 32'(in_ready), 32'd1);
            i = 0; cyc = 0;
            while (i < n && cyc < 4 * n + 50) begin
                if (i == abort_at) break;
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = 1'($urandom);
                endcase
                in_valid = v;
                in_data  = v ? q[i] : $urandom;
                hs = v & in_ready;
                @(negedge clk);
                cyc++;
                if (hs) i++;
            end
            in_valid = 1'b0;
            if (abort_at >= 0) begin
                rst_n = 1'b0;
                #1;
                chk_zero({tag, "_rst"});
                @(negedge clk);
                chk_zero({tag, "_rsthold"});
                rst_n = 1'b1;
                return;
            end
            chk({tag, "_consumed"}, 32'(i), 32'(n));
        end
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_iready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_val"}, max_val, mv);
        chk({tag, "_idx"}, 32'(max_idx), mi);
        chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
        for (int k = 0; k < hold; k++) begin
            start = 1'b1; len = 8'($urandom_range(1, 9)); out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_ovalid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_val"}, max_val, mv);
            chk({tag, "_hold_idx"}, 32'(max_idx), mi);
            chk({tag, "_hold_empty"}, 32'(empty), 32'(n == 0));
        end
        start = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drop_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drop_empty"}, 32'(empty), 32'd0);
    endtask

    initial begin
        // Comparator unit test: edges plus random pairs, both modes.
        for (int k = 0; k < 24; k++) begin
            case (k)
                0:       begin la = 32'h8000_0000; lb = 32'h7FFF_FFFF; end
                1:       begin la = 32'h7FFF_FFFF; lb = 32'hFFFF_FFFF; end
                2:       begin la = 32'h0000_0009; lb = 32'h0000_0009; end
                default: begin la = $urandom; lb = $urandom; end
            endcase
            lu = 1'(k % 2);
            #1;
            chk("less32", 32'(ll),
                32'(lu ? (la < lb) : ($signed(la) < $signed(lb))));
        end

        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");

        q = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd7};
        run_job("signed4", 1'b0, 4, 0, 0, -1);
        q = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        run_job("umode1", 1'b1, 3, 0, 0, -1);
        run_job("umode0", 1'b0, 3, 0, 0, -1);
        q = '{32'd9, 32'd9, 32'd9};
        run_job("ties", 1'b1, 3, 0, 0, -1);
        q = '{32'h8000_0000, 32'h8000_0000};
        run_job("smin", 1'b0, 2, 0, 0, -1);
        q = '{32'd5, 32'hFFFF_FFFD, 32'd12};
        run_job("bubbles", 1'b0, 3, 1, 0, -1);
        run_job("hold5", 1'b0, 3, 0, 5, -1);
        run_job("zero", 1'b0, 0, 0, 2, -1);
        q.delete();
        for (int k = 0; k < 255; k++) q.push_back(32'(k));
        run_job("len255", 1'(($urandom)), 255, 0, 0, -1);
        q = '{32'd50, 32'd60, 32'd70, 32'd80};
        run_job("abort", 1'b0, 4, 0, 0, 2);
        q = '{32'd1, 32'd2};
        run_job("fresh", 1'b0, 2, 0, 0, -1);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 24);
            q.delete();
            for (int k = 0; k < n; k++) begin
                // Narrow range sometimes to force ties.
                q.push_back((r % 2 == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom);
            end
            run_job("rand", 1'($urandom), n, 2, $urandom_range(0, 2), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/argmax_seq.md
# argmax_seq

Sequential arg-max engine for the DNN CPU's output stage. It accepts a stream of 32-bit scores over a valid/ready handshake and compares each against a running best with a single shared 32-bit less-than comparator. It returns the maximum value and its index, for example the predicted class after the final fully-connected layer. Signed or unsigned interpretation is selected per job.

## Interface
- `LEN_W`, 8: width of the element count and index; maximum job length is 2^LEN_W − 1.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: number of elements in the job, latched on accepted `start`.
- `umode` in 1: 1 = unsigned compare, 0 = two's-complement signed; latched on accepted `start`.
- `in_valid` in 1: score valid.
- `in_ready` out 1: engine can accept a score.
- `in_data` in 32: score.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `max_val` out 32: maximum score.
- `max_idx` out LEN_W: index (0-based) of the first occurrence of the maximum.
- `empty` out 1: job had `len` = 0; qualifies `max_val`/`max_idx` as meaningless (both 0).
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states:
  - IDLE:
    - `start` & `len` ≠ 0 → FIRST.
    - `start` & `len` = 0 → DONE with `empty` = 1.
  - FIRST: on the input handshake, best ← `in_data`, idx ← 0, count ← 1. Then count = `len` → DONE, else → RUN.
  - RUN: on each input handshake, with A = best and B = `in_data` compared under the latched `umode`:
    - If A < B: best ← B and idx ← count.
    - count increments.
    - When the incremented count equals `len` → DONE.
  - DONE: `out_valid` = 1. On `out_valid` & `out_ready` → IDLE, and `empty` clears.
- Ties (A = B) never update, so the lowest index wins.
- Signed compare treats bit 31 as sign: 0x80000000 is the minimum and 0x7FFFFFFF the maximum. Unsigned compare treats 0xFFFFFFFF as the maximum.
- `start` outside IDLE is ignored. `len` and `umode` changes after acceptance have no effect.
- `in_data` presented while `in_ready` = 0 is not consumed.
- Count and index never wrap: `len` ≤ 2^LEN_W − 1 bounds count.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `max_val` 0, `max_idx` 0, `empty` 0, `busy` 0, state IDLE, internal best/idx/count 0.
- `in_ready` = 1 exactly in FIRST and RUN, driven combinationally from state only. It does not depend on `in_valid`.
- Throughput: one score per cycle when `in_valid` is held high.
- Latency:
  - `start` accepted in cycle t → `in_ready` high at t+1.
  - Last score handshake at cycle t → `out_valid` high at t+1.
  - `len` = 0: `out_valid` at t+1 after `start`.
- `max_val`, `max_idx` and `empty` are registered and stable for the whole time `out_valid` is high.
- `out_valid` stays high until the handshake. It falls the cycle after the handshake. A new `start` is accepted from that IDLE cycle.
- Comparator path is combinational within one cycle: best register → compare → best/idx mux → registers.
- Reset asserted mid-job aborts immediately to the reset values. No partial result is produced.

## Structure
- Shared package `argmax_pkg`:
  - state enum `argmax_state_t` {IDLE, FIRST, RUN, DONE}.
  - constant `ARGMAX_DATA_W` = 32.
- One sub-module, `argmax_less32`: combinational `less = A < B`, with a `umode` select.
  - Signed mode flips bit 31 of both operands and then does an unsigned compare.
  - Unit-tested standalone.
- Top holds the FSM, the count/idx/best registers and the output registers.

## Test plan
- Signed job: `umode` = 0, `len` = 4, data {5, −3, 12, 7} streamed back-to-back → `max_val` = 12, `max_idx` = 2, `empty` = 0, `out_valid` 1 cycle after the 4th handshake.
- Unsigned vs signed on the same data {0x00000001, 0xFFFFFFFF, 0x7FFFFFFF}:
  - `umode` = 1 → `max_val` 0xFFFFFFFF, idx 1.
  - `umode` = 0 → `max_val` 0x7FFFFFFF, idx 2.
- Ties and sign extremes:
  - data {9, 9, 9} → `max_idx` = 0.
  - data {0x80000000, 0x80000000} signed → `max_val` 0x80000000, idx 0.
- Backpressure and bubbles:
  - `len` = 3, `in_valid` toggling 1-0-1-0-1 → same result as the back-to-back case, no element lost or duplicated.
  - `out_ready` held 0 for 5 cycles → `out_valid` and outputs stable; `start` during DONE ignored.
- Zero length and maximum length:
  - `len` = 0 → `out_valid` with `empty` = 1, `max_val`/`max_idx` = 0, no `in_ready` pulse.
  - `len` = 255 ascending 0..254 → `max_idx` = 254.
- Reset mid-job: assert `rst_n` low after 2 of 4 scores → all outputs 0, `busy` 0. A following fresh job with `len` = 2 {1, 2} → `max_val` 2, idx 1.
